// File: rtl/usb_sample_unpack.sv
// usb_sample_unpack: rebuilds stereo 32-bit frames {L,R} from the FX2 16-bit
// word stream (word order L-low, L-high, R-low, R-high) and buffers them in a
// first-word-fall-through frame FIFO with a registered almost_full throttle.
// Optional feature: define OVF_FLAG_EN to add a sticky ovf output that flags
// any frame dropped because the FIFO was full.
module usb_sample_unpack #(
  parameter int DEPTH_LOG2   = 3,
  parameter int AFULL_THRESH = 6
) (
  input  logic                  ifclk,
  input  logic                  rst,
  input  logic [15:0]           din,
  input  logic                  din_valid_n,
  input  logic                  sync,
  output logic                  almost_full,
  input  logic                  frame_rd,
  output logic [31:0]           frame_l,
  output logic [31:0]           frame_r,
  output logic                  frame_valid,
  output logic [DEPTH_LOG2:0]   level
`ifdef OVF_FLAG_EN
  ,
  output logic                  ovf
`endif
);

  localparam int                  DEPTH     = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] LVL_FULL  = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0] LVL_AFULL = (DEPTH_LOG2+1)'(AFULL_THRESH);
  localparam logic [DEPTH_LOG2:0] LVL_ONE   = {{DEPTH_LOG2{1'b0}}, 1'b1};
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};

  logic [1:0]            phase_r;
  logic [47:0]           stage_r;
  logic [DEPTH_LOG2-1:0] wr_ptr_r;
  logic [DEPTH_LOG2-1:0] rd_ptr_r;
  logic [DEPTH_LOG2:0]   level_r;
  logic                  almost_full_r;
  logic [31:0]           mem_l_r [DEPTH];
  logic [31:0]           mem_r_r [DEPTH];

  logic                  accept_s;
  logic [1:0]            eff_phase_s;
  logic [1:0]            phase_nxt_s;
  logic [47:0]           stage_nxt_s;
  logic                  push_s;
  logic                  pop_s;
  logic                  full_s;
  logic                  wr_en_s;
  logic                  drop_s;
  logic [31:0]           push_l_s;
  logic [31:0]           push_r_s;

  // Word assembly: sync restarts the frame, then the accepted word lands in its slot.
  always_comb begin
    accept_s    = ~din_valid_n;
    eff_phase_s = sync ? 2'd0 : phase_r;
    stage_nxt_s = sync ? 48'd0 : stage_r;
    phase_nxt_s = eff_phase_s;
    if (accept_s) begin
      case (eff_phase_s)
        2'd0:    stage_nxt_s[15:0]  = din;
        2'd1:    stage_nxt_s[31:16] = din;
        2'd2:    stage_nxt_s[47:32] = din;
        default: stage_nxt_s        = stage_nxt_s;
      endcase
      phase_nxt_s = eff_phase_s + 2'd1;
    end else begin
      phase_nxt_s = eff_phase_s;
    end
  end

  // FIFO control: a push into a full FIFO only lands when a pop frees a slot.
  always_comb begin
    push_s   = accept_s && (eff_phase_s == 2'd3);
    push_l_s = stage_nxt_s[31:0];
    push_r_s = {din, stage_nxt_s[47:32]};
    pop_s    = frame_rd && (level_r != '0);
    full_s   = (level_r == LVL_FULL);
    wr_en_s  = push_s && (!full_s || pop_s);
    drop_s   = push_s && full_s && !pop_s;
  end

  // Phase, staging, pointers, level and throttle registers.
  always_ff @(posedge ifclk) begin
    if (rst) begin
      phase_r       <= 2'd0;
      stage_r       <= 48'd0;
      wr_ptr_r      <= '0;
      rd_ptr_r      <= '0;
      level_r       <= '0;
      almost_full_r <= 1'b0;
    end else begin
      phase_r       <= phase_nxt_s;
      stage_r       <= stage_nxt_s;
      almost_full_r <= (level_r >= LVL_AFULL);
      if (wr_en_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({wr_en_s, pop_s})
        2'b10:   level_r <= level_r + LVL_ONE;
        2'b01:   level_r <= level_r - LVL_ONE;
        default: level_r <= level_r;
      endcase
    end
  end

  // Frame storage; contents need no reset because level gates visibility.
  always_ff @(posedge ifclk) begin
    if (wr_en_s && !rst) begin
      mem_l_r[wr_ptr_r] <= push_l_s;
      mem_r_r[wr_ptr_r] <= push_r_s;
    end
  end

`ifdef OVF_FLAG_EN
  logic ovf_r;

  // Sticky overflow flag, cleared only by reset.
  always_ff @(posedge ifclk) begin
    if (rst) begin
      ovf_r <= 1'b0;
    end else if (drop_s) begin
      ovf_r <= 1'b1;
    end
  end

  assign ovf = ovf_r;
`else
  logic unused_drop_s;
  assign unused_drop_s = drop_s;
`endif

  assign frame_l     = mem_l_r[rd_ptr_r];
  assign frame_r     = mem_r_r[rd_ptr_r];
  assign frame_valid = (level_r != '0);
  assign level       = level_r;
  assign almost_full = almost_full_r;

endmodule

// File: tb/tb_usb_sample_unpack.sv
// Directed self-checking bench for usb_sample_unpack (default parameters).
module tb_usb_sample_unpack;

  logic        ifclk;
  logic        rst;
  logic [15:0] din;
  logic        din_valid_n;
  logic        sync;
  logic        almost_full;
  logic        frame_rd;
  logic [31:0] frame_l;
  logic [31:0] frame_r;
  logic        frame_valid;
  logic [3:0]  level;
`ifdef OVF_FLAG_EN
  logic        ovf;
`endif

  int checks = 0;
  int errors = 0;

  usb_sample_unpack #(.DEPTH_LOG2(3), .AFULL_THRESH(6)) dut (
    .ifclk       (ifclk),
    .rst         (rst),
    .din         (din),
    .din_valid_n (din_valid_n),
    .sync        (sync),
    .almost_full (almost_full),
    .frame_rd    (frame_rd),
    .frame_l     (frame_l),
    .frame_r     (frame_r),
    .frame_valid (frame_valid),
    .level       (level)
`ifdef OVF_FLAG_EN
    ,
    .ovf         (ovf)
`endif
  );

  initial ifclk = 1'b0;
  always #5 ifclk = ~ifclk;

  task automatic step();
    @(posedge ifclk);
    #1;
  endtask

  task automatic word(input logic [15:0] w);
    din         = w;
    din_valid_n = 1'b0;
    step();
    din_valid_n = 1'b1;
  endtask

  task automatic push_frame(input logic [15:0] base);
    word(base);
    word(base + 16'd1);
    word(base + 16'd2);
    word(base + 16'd3);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [15:0] b;
    rst = 1'b1; din = 16'd0; din_valid_n = 1'b1; sync = 1'b0; frame_rd = 1'b0;
    step(); step();
    rst = 1'b0;
    check("rst_valid", {31'd0, frame_valid}, 32'd0);
    check("rst_level", {28'd0, level}, 32'd0);
    check("rst_afull", {31'd0, almost_full}, 32'd0);

    // Basic frame assembly
    word(16'h0001); word(16'h0002); word(16'h0003);
    check("partial_level", {28'd0, level}, 32'd0);
    word(16'h0004);
    check("basic_valid", {31'd0, frame_valid}, 32'd1);
    check("basic_l", frame_l, 32'h0002_0001);
    check("basic_r", frame_r, 32'h0004_0003);
    check("basic_level", {28'd0, level}, 32'd1);
    frame_rd = 1'b1; step(); frame_rd = 1'b0;
    check("pop_level", {28'd0, level}, 32'd0);
    check("pop_valid", {31'd0, frame_valid}, 32'd0);

    // Sync with a word in the same cycle
    word(16'hAAAA); word(16'hBBBB);
    sync = 1'b1; word(16'h1111); sync = 1'b0;
    word(16'h2222); word(16'h3333);
    check("sync_partial", {28'd0, level}, 32'd0);
    word(16'h4444);
    check("sync_l", frame_l, 32'h2222_1111);
    check("sync_r", frame_r, 32'h4444_3333);
    frame_rd = 1'b1; step(); frame_rd = 1'b0;

    // Sync alone discards the partial frame
    word(16'h0005); word(16'h0006);
    sync = 1'b1; step(); sync = 1'b0;
    push_frame(16'h0007);
    check("sync_only_level", {28'd0, level}, 32'd1);
    check("sync_only_l", frame_l, 32'h0008_0007);
    check("sync_only_r", frame_r, 32'h000A_0009);
    frame_rd = 1'b1; step(); frame_rd = 1'b0;
    check("sync_only_empty", {28'd0, level}, 32'd0);

    // Fill to the almost-full threshold, then to full, then overflow
    for (int k = 1; k <= 6; k++) push_frame(16'(k << 8));
    check("fill6_level", {28'd0, level}, 32'd6);
    check("fill6_afull_lag", {31'd0, almost_full}, 32'd0);
    step();
    check("fill6_afull", {31'd0, almost_full}, 32'd1);
    push_frame(16'h0700); push_frame(16'h0800);
    check("full_level", {28'd0, level}, 32'd8);
    push_frame(16'h0900);
    check("drop_level", {28'd0, level}, 32'd8);
    check("drop_head_l", frame_l, 32'h0101_0100);
`ifdef OVF_FLAG_EN
    check("drop_ovf", {31'd0, ovf}, 32'd1);
`endif

    // Push completes while full in the same cycle as a pop
    word(16'h0A00); word(16'h0A01); word(16'h0A02);
    din = 16'h0A03; din_valid_n = 1'b0; frame_rd = 1'b1;
    step();
    din_valid_n = 1'b1; frame_rd = 1'b0;
    check("pushpop_level", {28'd0, level}, 32'd8);
    for (int i = 0; i < 8; i++) begin
      b = (i < 7) ? 16'((i + 2) << 8) : 16'h0A00;
      check("drain_l", frame_l, {b + 16'd1, b});
      check("drain_r", frame_r, {b + 16'd3, b + 16'd2});
      frame_rd = 1'b1; step(); frame_rd = 1'b0;
    end
    check("drain_level", {28'd0, level}, 32'd0);
    check("drain_valid", {31'd0, frame_valid}, 32'd0);

    // Read held beyond empty
    push_frame(16'h1100); push_frame(16'h1200); push_frame(16'h1300);
    check("rd3_level", {28'd0, level}, 32'd3);
    frame_rd = 1'b1;
    check("rd3_head0", frame_l, 32'h1101_1100);
    step();
    check("rd3_head1", frame_l, 32'h1201_1200);
    step();
    check("rd3_head2", frame_r, 32'h1303_1302);
    step(); step(); step();
    frame_rd = 1'b0;
    check("rd3_level0", {28'd0, level}, 32'd0);
    check("rd3_valid0", {31'd0, frame_valid}, 32'd0);
    push_frame(16'h1400);
    check("rd3_after_level", {28'd0, level}, 32'd1);
    check("rd3_after_l", frame_l, 32'h1401_1400);
    check("rd3_after_r", frame_r, 32'h1403_1402);

    // Reset mid-frame with a competing word, read and sync
    word(16'h5555); word(16'h6666);
    rst = 1'b1; din = 16'hDEAD; din_valid_n = 1'b0; frame_rd = 1'b1; sync = 1'b1;
    step();
    rst = 1'b0; din_valid_n = 1'b1; frame_rd = 1'b0; sync = 1'b0;
    check("mid_rst_level", {28'd0, level}, 32'd0);
    check("mid_rst_afull", {31'd0, almost_full}, 32'd0);
`ifdef OVF_FLAG_EN
    check("mid_rst_ovf", {31'd0, ovf}, 32'd0);
`endif
    push_frame(16'h7000);
    check("post_rst_level", {28'd0, level}, 32'd1);
    check("post_rst_l", frame_l, 32'h7001_7000);
    check("post_rst_r", frame_r, 32'h7003_7002);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/usb_sample_unpack.md
USB_SAMPLE_UNPACK -- requirements
Module: usb_sample_unpack

Interface
REQ-001 The block SHALL have parameter DEPTH_LOG2, default 3: log2 of the frame FIFO depth (8 frames).
REQ-002 The block SHALL have parameter AFULL_THRESH, default 6: fill level at and above which almost_full asserts.
REQ-003 The block SHALL have port ifclk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port din, input, 16 bits: word from the FX2 slave-FIFO interface.
REQ-006 The block SHALL have port din_valid_n, input, 1 bit: active-low strobe; din is accepted on each ifclk edge where it is low.
REQ-007 The block SHALL have port sync, input, 1 bit: realigns word phase to L-low.
REQ-008 The block SHALL have port almost_full, output, 1 bit: throttle request back to the FX2 interface.
REQ-009 The block SHALL have port frame_rd, input, 1 bit: consumer pop of the head frame.
REQ-010 The block SHALL have port frame_l, output, 32 bits: left sample of the head frame.
REQ-011 The block SHALL have port frame_r, output, 32 bits: right sample of the head frame.
REQ-012 The block SHALL have port frame_valid, output, 1 bit: FIFO non-empty, so frame_l/frame_r are valid.
REQ-013 The block SHALL have port level, output, DEPTH_LOG2+1 bits: frames stored, 0..2^DEPTH_LOG2.

Function
REQ-014 The block SHALL keep a 2-bit word phase: 0 = L[15:0], 1 = L[31:16], 2 = R[15:0], 3 = R[31:16]; the phase advances modulo 4 on each accepted word.
REQ-015 The block SHALL hold words at phases 0-2 in a staging register; the word at phase 3 SHALL complete frame {L,R}, which is pushed in the same cycle.
REQ-016 sync=1 SHALL discard the staged partial frame and force the phase to 0; if din_valid_n=0 in the same cycle, that word SHALL be taken as phase 0, and the next phase SHALL be 1.
REQ-017 The FIFO SHALL be first-word-fall-through: frame_valid = (level != 0), and frame_l/frame_r SHALL show the head frame combinationally from storage.
REQ-018 A push into an empty FIFO SHALL make frame_valid high on the next cycle (1-cycle latency).
REQ-019 frame_rd with frame_valid=1 SHALL advance the head on the next edge; frame_rd with frame_valid=0 SHALL be ignored.
REQ-020 A push while level is full and frame_rd=0 SHALL drop the completed frame; FIFO contents and level SHALL be unchanged, and the phase SHALL still wrap to 0.
REQ-021 A simultaneous push and valid pop SHALL leave level unchanged and SHALL accept the push, including when the FIFO is full.
REQ-022 Read and write pointers SHALL be DEPTH_LOG2 bits and SHALL wrap naturally; level SHALL be a separate up/down counter.
REQ-023 almost_full SHALL be registered and SHALL equal (level >= AFULL_THRESH) as of the previous edge.

Reset
REQ-024 On rst=1 at an ifclk edge, the block SHALL set phase=0, clear the staging register, set both pointers=0, level=0, frame_valid=0 and almost_full=0; it SHALL also set ovf=0 when OVF_FLAG_EN is defined.
REQ-025 Reset SHALL take priority over din_valid_n, sync and frame_rd in the same cycle, and a partial frame SHALL be discarded.
REQ-026 frame_l and frame_r SHALL be don't-care while frame_valid=0.

Configuration
REQ-027 When macro OVF_FLAG_EN is defined, the block SHALL add output ovf, 1 bit, which sets sticky on any dropped frame (REQ-020) and clears only on rst.
REQ-028 When OVF_FLAG_EN is undefined, the ovf port and its logic SHALL be absent, and drop behaviour SHALL be unchanged.

Verification
REQ-029 Scenario: after reset, feed words 0x0001,0x0002,0x0003,0x0004 -> next cycle frame_valid=1, frame_l=0x00020001, frame_r=0x00040003, level=1.
REQ-030 Scenario: feed 0xAAAA,0xBBBB, pulse sync together with 0x1111, then feed 0x2222,0x3333,0x4444 -> frame_l=0x22221111, frame_r=0x44443333.
REQ-031 Scenario: push 6 frames with no reads -> almost_full=1 the cycle after level reaches 6; push 3 more frames -> level=8, the 9th frame is dropped, and ovf=1 when OVF_FLAG_EN is defined.
REQ-032 Scenario: with FIFO full, complete a frame in the same cycle as frame_rd=1 -> level stays 8, no drop, and the new frame is read last after the 7 older frames.
REQ-033 Scenario: with level=3, frame_rd held high 5 cycles -> 3 frames popped in order, level=0, frame_valid=0, extra reads ignored and pointers not disturbed.
REQ-034 Scenario: assert rst after 2 words of a frame, then feed 4 words -> exactly one frame is built from the post-reset words only.
